// File: rtl/efpga_filter_violation_log.sv
// ----------------------------------------------------------------------------
// efpga_filter_violation_log
//
// Records every request blocked by the eFPGA AES address filter in a small
// first-word-fall-through log. Each entry holds the address, the read/write
// direction and the IP select. The block also keeps saturating event and drop
// counters, a sticky overflow flag and a sticky threshold alert. Firmware
// drains the log through a valid/pop read port.
//
// Optional build macro: FILTER_LOG_TIMESTAMP_EN
//   When it is defined, a free-running 16-bit cycle counter is added. Each
//   entry then becomes {ts[15:0], blk_ip, blk_rd_wr, blk_addr} (42 bits).
//   When it is undefined, the entry is {blk_ip, blk_rd_wr, blk_addr} (26 bits).
//
// Parameters:
//   DEPTH         log entries (power of two, 2..64)
//   CNT_W         width of blocked_cnt_o / drop_cnt_o
//   ALERT_THRESH  blocked count at which alert_o sets (1..2^CNT_W-1)
//
// Ports:
//   clk            clock, rising edge
//   reset          synchronous, active-low
//   blk_valid_i    one-cycle pulse per blocked request
//   blk_addr_i     23-bit address of the blocked request
//   blk_rd_wr_i    1 = write, 0 = read
//   blk_ip_i       IP select at block time
//   pop_i          consume the head entry (ignored when the log is empty)
//   clr_i          clear counters, overflow_o and alert_o (log is kept)
//   rd_valid_o     log non-empty
//   rd_data_o      head entry
//   fill_o         current entry count
//   blocked_cnt_o  saturating count of all blocked events
//   drop_cnt_o     saturating count of events lost to a full log
//   overflow_o     sticky, set on the first drop
//   alert_o        sticky, set once blocked_cnt_o >= ALERT_THRESH
// ----------------------------------------------------------------------------
module efpga_filter_violation_log #(
    parameter int DEPTH        = 8,
    parameter int CNT_W        = 8,
    parameter int ALERT_THRESH = 4,
`ifdef FILTER_LOG_TIMESTAMP_EN
    localparam int ENTRY_W     = 42,
`else
    localparam int ENTRY_W     = 26,
`endif
    localparam int PTR_W       = $clog2(DEPTH),
    localparam int FILL_W      = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               blk_valid_i,
    input  logic [22:0]        blk_addr_i,
    input  logic               blk_rd_wr_i,
    input  logic [1:0]         blk_ip_i,
    input  logic               pop_i,
    input  logic               clr_i,
    output logic               rd_valid_o,
    output logic [ENTRY_W-1:0] rd_data_o,
    output logic [FILL_W-1:0]  fill_o,
    output logic [CNT_W-1:0]   blocked_cnt_o,
    output logic [CNT_W-1:0]   drop_cnt_o,
    output logic               overflow_o,
    output logic               alert_o
);

    localparam logic [FILL_W-1:0] DEPTH_F  = FILL_W'(DEPTH);
    localparam logic [CNT_W-1:0]  THRESH_C = CNT_W'(ALERT_THRESH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    // Saturating increment shared by both event counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [FILL_W-1:0]  fill;

    logic               empty;
    logic               full;
    logic               do_pop;
    logic               do_push;
    logic               do_drop;
    logic [ENTRY_W-1:0] entry_new;

    logic [CNT_W-1:0]   blocked_base;
    logic [CNT_W-1:0]   drop_base;
    logic [CNT_W-1:0]   blocked_nxt;
    logic [CNT_W-1:0]   drop_nxt;
    logic               overflow_nxt;
    logic               alert_nxt;

`ifdef FILTER_LOG_TIMESTAMP_EN
    logic [15:0]        ts_cnt;

    // Free-running cycle counter; only reset clears it, clr_i does not.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
        end
    end

    assign entry_new = {ts_cnt, blk_ip_i, blk_rd_wr_i, blk_addr_i};
`else
    assign entry_new = {blk_ip_i, blk_rd_wr_i, blk_addr_i};
`endif

    // ---- stage p0: push/pop/drop decision from current occupancy ----
    assign empty   = (fill == '0);
    assign full    = (fill == DEPTH_F);
    // A pop on an empty log is a no-op. This also makes a same-cycle
    // push+pop on an empty log degrade to a plain push.
    assign do_pop  = pop_i & ~empty;
    // When the log is full, a concurrent pop frees the slot for the push.
    assign do_push = blk_valid_i & (~full | do_pop);
    assign do_drop = blk_valid_i & ~do_push;

    // The clear is applied first, so a same-cycle event counts from zero.
    // The alert is then re-evaluated against the post-clear count.
    always_comb begin
        blocked_base = clr_i ? '0 : blocked_cnt_o;
        drop_base    = clr_i ? '0 : drop_cnt_o;
        blocked_nxt  = blk_valid_i ? sat_inc(blocked_base) : blocked_base;
        drop_nxt     = do_drop ? sat_inc(drop_base) : drop_base;
        overflow_nxt = (overflow_o & ~clr_i) | do_drop;
        alert_nxt    = (alert_o & ~clr_i) | (blocked_nxt >= THRESH_C);
    end

    // ---- stage p1: registered pointers, fill and status ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill          <= '0;
            blocked_cnt_o <= '0;
            drop_cnt_o    <= '0;
            overflow_o    <= 1'b0;
            alert_o       <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: fill <= fill;
            endcase
            blocked_cnt_o <= blocked_nxt;
            drop_cnt_o    <= drop_nxt;
            overflow_o    <= overflow_nxt;
            alert_o       <= alert_nxt;
        end
    end

    // Storage is data-only and is never reset. Writes are gated in the
    // reset cycle so that no partial entry is left behind.
    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            mem[wr_ptr] <= entry_new;
        end
    end

    // First-word-fall-through read. The head stays stable while the log is
    // empty because nothing writes at rd_ptr until the next push.
    assign rd_data_o  = mem[rd_ptr];
    assign rd_valid_o = ~empty;
    assign fill_o     = fill;

endmodule
